// File: rtl/lfsr_rng.sv
// Parametrised Fibonacci LFSR with reseed, all-zero recovery and a
// rejection-sampled bounded request/response port.
module lfsr_rng #(
  parameter int               WIDTH     = 10,
  parameter logic [WIDTH-1:0] TAPS      = 10'h240,
  parameter logic [WIDTH-1:0] SEED      = 10'h001,
  parameter int               OUT_W     = 8,
  parameter int               MAX_TRIES = 16
) (
  input  logic             clk_22,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] num,
  output logic             lockup_o,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W-1:0] limit_i,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic             rsp_timeout
);

  localparam int               TW       = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0]    TRY_LAST = TW'(MAX_TRIES - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == ZERO) ? ONE : SEED;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESP   = 2'd2
  } fsm_t;

  fsm_t             fsm_r, fsm_nxt_s;
  logic [WIDTH-1:0] state_r, state_nxt_s;
  logic             lockup_r, lockup_nxt_s;
  logic [OUT_W-1:0] limit_r, limit_nxt_s;
  logic [OUT_W-1:0] cand_s;
  logic [OUT_W-1:0] rsp_data_r, rsp_data_nxt_s;
  logic             rsp_timeout_r, rsp_timeout_nxt_s;
  logic [TW-1:0]    tries_r, tries_nxt_s;
  logic             req_ready_r, rsp_valid_r;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  assign cand_s = state_r[OUT_W-1:0];

  // LFSR state next value: load beats lock-up recovery beats stepping.
  always_comb begin
    state_nxt_s  = state_r;
    lockup_nxt_s = 1'b0;
    if (load) begin
      state_nxt_s = (seed_i == ZERO) ? ONE : seed_i;
    end else if (state_r == ZERO) begin
      state_nxt_s  = ONE;
      lockup_nxt_s = 1'b1;
    end else if (en || (fsm_r == SEARCH)) begin
      state_nxt_s = lfsr_step(state_r);
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Request FSM next state and response capture.
  always_comb begin
    fsm_nxt_s         = fsm_r;
    limit_nxt_s       = limit_r;
    tries_nxt_s       = tries_r;
    rsp_data_nxt_s    = rsp_data_r;
    rsp_timeout_nxt_s = rsp_timeout_r;
    case (fsm_r)
      IDLE: begin
        if (req_valid) begin
          limit_nxt_s = limit_i;
          tries_nxt_s = {TW{1'b0}};
          fsm_nxt_s   = SEARCH;
        end else begin
          fsm_nxt_s = IDLE;
        end
      end
      SEARCH: begin
        if (cand_s <= limit_r) begin
          rsp_data_nxt_s    = cand_s;
          rsp_timeout_nxt_s = 1'b0;
          fsm_nxt_s         = RESP;
        end else if (tries_r == TRY_LAST) begin
          // Bound itself is always a legal fallback value.
          rsp_data_nxt_s    = limit_r;
          rsp_timeout_nxt_s = 1'b1;
          fsm_nxt_s         = RESP;
        end else begin
          tries_nxt_s = tries_r + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          fsm_nxt_s = IDLE;
        end else begin
          fsm_nxt_s = RESP;
        end
      end
      default: begin
        fsm_nxt_s = IDLE;
      end
    endcase
  end

  // State, FSM and registered outputs.
  always_ff @(posedge clk_22 or negedge rst) begin
    if (!rst) begin
      state_r       <= SEED_EFF;
      lockup_r      <= 1'b0;
      fsm_r         <= IDLE;
      limit_r       <= {OUT_W{1'b0}};
      tries_r       <= {TW{1'b0}};
      rsp_data_r    <= {OUT_W{1'b0}};
      rsp_timeout_r <= 1'b0;
      req_ready_r   <= 1'b1;
      rsp_valid_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      lockup_r      <= lockup_nxt_s;
      fsm_r         <= fsm_nxt_s;
      limit_r       <= limit_nxt_s;
      tries_r       <= tries_nxt_s;
      rsp_data_r    <= rsp_data_nxt_s;
      rsp_timeout_r <= rsp_timeout_nxt_s;
      req_ready_r   <= (fsm_nxt_s == IDLE);
      rsp_valid_r   <= (fsm_nxt_s == RESP);
    end
  end

  assign num         = state_r;
  assign lockup_o    = lockup_r;
  assign req_ready   = req_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_data    = rsp_data_r;
  assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_lfsr_rng.sv
// Bench for lfsr_rng: default instance with randomized requests against a
// behavioural model, plus short-timeout and lock-up-prone instances.
module tb_lfsr_rng;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a_en = 1'b0, a_load = 1'b0, a_rqv = 1'b0, a_rsr = 1'b0;
  logic [9:0] a_seed = 10'd0, a_num;
  logic [7:0] a_lim = 8'd0, a_dat;
  logic       a_lock, a_rqr, a_rsv, a_to;

  logic       b_en = 1'b0, b_load = 1'b0, b_rqv = 1'b0, b_rsr = 1'b0;
  logic [9:0] b_seed = 10'd0, b_num;
  logic [7:0] b_lim = 8'd0, b_dat;
  logic       b_lock, b_rqr, b_rsv, b_to;

  logic       c_en = 1'b0, c_load = 1'b0, c_rqv = 1'b0, c_rsr = 1'b0;
  logic [9:0] c_seed = 10'd0, c_num;
  logic [7:0] c_lim = 8'd0, c_dat;
  logic       c_lock, c_rqr, c_rsv, c_to;

  lfsr_rng dut_a (
    .clk_22(clk), .rst(rst), .en(a_en), .load(a_load), .seed_i(a_seed),
    .num(a_num), .lockup_o(a_lock), .req_valid(a_rqv), .req_ready(a_rqr),
    .limit_i(a_lim), .rsp_valid(a_rsv), .rsp_ready(a_rsr),
    .rsp_data(a_dat), .rsp_timeout(a_to));

  lfsr_rng #(.MAX_TRIES(2)) dut_b (
    .clk_22(clk), .rst(rst), .en(b_en), .load(b_load), .seed_i(b_seed),
    .num(b_num), .lockup_o(b_lock), .req_valid(b_rqv), .req_ready(b_rqr),
    .limit_i(b_lim), .rsp_valid(b_rsv), .rsp_ready(b_rsr),
    .rsp_data(b_dat), .rsp_timeout(b_to));

  lfsr_rng #(.TAPS(10'h004)) dut_c (
    .clk_22(clk), .rst(rst), .en(c_en), .load(c_load), .seed_i(c_seed),
    .num(c_num), .lockup_o(c_lock), .req_valid(c_rqv), .req_ready(c_rqr),
    .limit_i(c_lim), .rsp_valid(c_rsv), .rsp_ready(c_rsr),
    .rsp_data(c_dat), .rsp_timeout(c_to));

  int checks = 0;
  int failures = 0;
  int ms = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Next LFSR value: double modulo 1024, plus the parity of the tapped bits.
  function automatic int mstep(input int s, input int taps);
    return ((s * 2) % 1024) + ($countones(s & taps) % 2);
  endfunction

  task automatic model_req(input int s, input int lim, input int mt,
                           output int data, output int to, output int r, output int s_out);
    int  cur = s;
    bit  done = 1'b0;
    r = 0; data = 0; to = 0;
    for (int t = 0; t < mt && !done; t++) begin
      if ((cur % 256) <= lim) begin
        data = cur % 256; to = 0; done = 1'b1;
      end else if (t == mt - 1) begin
        data = lim; to = 1; done = 1'b1;
      end else begin
        r++;
      end
      cur = mstep(cur, 'h240);
    end
    s_out = cur;
  endtask

  task automatic a_reseed(input int v);
    a_seed = 10'(v);
    a_load = 1'b1;
    tick;
    a_load = 1'b0;
    ms = (v == 0) ? 1 : v;
    chk("a_load_num", a_num, ms);
    chk("a_load_nolock", a_lock, 0);
  endtask

  task automatic a_request(input int lim, input int hold, output int lat, output int dat);
    int d, t, r, ns;
    model_req(ms, lim, 16, d, t, r, ns);
    chk("a_req_ready_idle", a_rqr, 1);
    a_lim = 8'(lim);
    a_rqv = 1'b1;
    tick;
    a_rqv = 1'b0;
    lat = 1;
    chk("a_req_ready_busy", a_rqr, 0);
    while (a_rsv !== 1'b1 && lat < 40) begin
      tick;
      lat++;
    end
    dat = int'(a_dat);
    chk("a_latency", lat, 2 + r);
    chk("a_data", a_dat, d);
    chk("a_timeout", a_to, t);
    chk("a_num_at_rsp", a_num, ns);
    for (int k = 0; k < hold; k++) begin
      tick;
      chk("a_hold_valid", a_rsv, 1);
      chk("a_hold_data", a_dat, d);
      chk("a_hold_ready", a_rqr, 0);
    end
    a_rsr = 1'b1;
    tick;
    a_rsr = 1'b0;
    chk("a_rsp_done", a_rsv, 0);
    chk("a_ready_back", a_rqr, 1);
    ms = ns;
  endtask

  initial begin
    int seq[11] = '{1, 2, 4, 8, 16, 32, 64, 129, 258, 516, 9};
    int lat, dat, early, cyc;

    // Reset values
    a_en = 1'b1;
    tick;
    tick;
    chk("rst_num", a_num, 1);
    chk("rst_req_ready", a_rqr, 1);
    chk("rst_rsp_valid", a_rsv, 0);
    chk("rst_rsp_timeout", a_to, 0);
    chk("rst_lockup", a_lock, 0);
    chk("rst_rsp_data", a_dat, 0);
    chk("rst_b_num", b_num, 1);
    rst = 1'b1;

    // Free-running sequence and full period
    ms = 1;
    early = 0;
    for (int i = 0; i < 1023; i++) begin
      if (i < 11) chk("seq_const", a_num, seq[i]);
      tick;
      ms = mstep(ms, 'h240);
      chk("seq_model", a_num, ms);
      if (i < 1022 && (a_num == 10'd1 || a_num == 10'd0)) early++;
    end
    a_en = 1'b0;
    chk("period_return", a_num, 1);
    chk("period_early", early, 0);

    // Immediate accept with stalled response
    a_lim = 8'd200;
    a_rqv = 1'b1;
    tick;
    a_rqv = 1'b0;
    chk("imm_c1_valid", a_rsv, 0);
    chk("imm_c1_ready", a_rqr, 0);
    tick;
    chk("imm_c2_valid", a_rsv, 1);
    chk("imm_c2_data", a_dat, 1);
    chk("imm_c2_timeout", a_to, 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("imm_stall_valid", a_rsv, 1);
      chk("imm_stall_data", a_dat, 1);
      chk("imm_stall_timeout", a_to, 0);
    end
    a_rsr = 1'b1;
    tick;
    a_rsr = 1'b0;
    chk("imm_done_valid", a_rsv, 0);
    chk("imm_done_ready", a_rqr, 1);
    chk("imm_num", a_num, 2);
    ms = 2;

    // Rejection from seed 16
    a_reseed(16);
    a_request(3, 1, lat, dat);
    chk("rej_cycle", lat, 6);
    chk("rej_data", dat, 2);

    // Zero seed maps to 1
    a_reseed(0);
    chk("zero_seed_num", a_num, 1);

    // Randomized requests, reseeds and boundary limits
    for (int n = 0; n < 24; n++) begin
      int lim;
      if ($urandom_range(0, 3) == 0)
        a_reseed(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 1023)));
      case ($urandom_range(0, 3))
        0: lim = 0;
        1: lim = 255;
        default: lim = int'($urandom_range(0, 255));
      endcase
      a_request(lim, int'($urandom_range(0, 2)), lat, dat);
    end

    // Timeout on the MAX_TRIES=2 instance
    b_seed = 10'd16;
    b_load = 1'b1;
    tick;
    b_load = 1'b0;
    b_lim = 8'd0;
    b_rqv = 1'b1;
    tick;
    b_rqv = 1'b0;
    cyc = 1;
    while (b_rsv !== 1'b1 && cyc < 20) begin
      tick;
      cyc++;
    end
    chk("to_cycle", cyc, 3);
    chk("to_data", b_dat, 0);
    chk("to_flag", b_to, 1);
    chk("to_num", b_num, 64);
    b_rsr = 1'b1;
    tick;
    b_rsr = 1'b0;
    chk("to_done", b_rsv, 0);

    // Lock-up recovery on the TAPS=004 instance
    c_en = 1'b1;
    c_seed = 10'h200;
    c_load = 1'b1;
    tick;
    c_load = 1'b0;
    chk("lk_loaded", c_num, 10'h200);
    tick;
    chk("lk_zero", c_num, 0);
    chk("lk_zero_pulse", c_lock, 0);
    tick;
    chk("lk_one", c_num, 1);
    chk("lk_pulse", c_lock, 1);
    tick;
    chk("lk_after", c_num, 2);
    chk("lk_pulse_end", c_lock, 0);
    c_en = 1'b0;
    c_seed = 10'd0;
    c_load = 1'b1;
    tick;
    c_load = 1'b0;
    chk("lk_zero_seed", c_num, 1);
    chk("lk_zero_seed_nopulse", c_lock, 0);

    // Reset in the middle of a search
    a_reseed(16);
    a_lim = 8'd3;
    a_rqv = 1'b1;
    tick;
    a_rqv = 1'b0;
    tick;
    chk("mid_searching", a_rqr, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", a_rsv, 0);
    chk("mid_rst_num", a_num, 1);
    chk("mid_rst_ready", a_rqr, 1);
    chk("mid_rst_data", a_dat, 0);
    tick;
    chk("mid_rst_hold_valid", a_rsv, 0);
    rst = 1'b1;
    ms = 1;
    a_request(200, 0, lat, dat);
    chk("mid_after_data", dat, 1);
    chk("mid_after_lat", lat, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_rng.md
# lfsr_rng

Parametrised Fibonacci LFSR random-number generator. Successor to the fixed 10-bit free-running LFSR used by the game logic. Adds configurable width, tap mask and seed, runtime reseeding, all-zero lock-up recovery, and a request/response port that returns a value bounded to a runtime limit by rejection sampling. Sits on the `clk_22` domain, feeding spawn-position and timing randomisation.

## Interface
- `WIDTH`, 10: LFSR state width, ≥ 3.
- `TAPS`, 10'h240: feedback tap mask (bit i set = state[i] is XORed into feedback). The default gives a maximal-length 10-bit sequence with period 1023.
- `SEED`, 10'h001: reset state. If it is 0, 1 is used instead.
- `OUT_W`, 8: width of the bounded output, ≤ WIDTH.
- `MAX_TRIES`, 16: rejection attempts per request before timeout, ≥ 1.

Ports:
- `clk_22` input 1: clock.
- `rst` input 1: reset. Asynchronous, active-low.
- `en` input 1: free-running step enable.
- `load` input 1: reseed strobe.
- `seed_i` input WIDTH: reseed value.
- `num` output WIDTH: current LFSR state.
- `lockup_o` output 1: one-cycle pulse on all-zero recovery.
- `req_valid` input 1: bounded-value request.
- `req_ready` output 1: high in IDLE only.
- `limit_i` input OUT_W: inclusive upper bound, sampled at request handshake.
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: response accept.
- `rsp_data` output OUT_W: bounded value.
- `rsp_timeout` output 1: response is the timeout fallback.

## Operation
- **Step function:** `state <= {state[WIDTH-2:0], ^(state & TAPS)}`.
- **State update priority per cycle:**
  1. `load`: state <= `seed_i`, or 1 if `seed_i` is 0.
  2. Lock-up: if state == 0, state <= 1 and `lockup_o` = 1 on the next cycle.
  3. Step: taken if `en` = 1 or FSM = SEARCH.
  4. Otherwise hold.
- `num` = state, always.
- **FSM states:** IDLE, SEARCH, RESP.
  - IDLE: `req_ready` = 1. On `req_valid` = 1, capture `limit_q <= limit_i`, clear `tries`, go to SEARCH.
  - SEARCH, evaluated every cycle on the current state:
    - `cand = state[OUT_W-1:0]`.
    - If `cand <= limit_q`: `rsp_data <= cand`, `rsp_timeout <= 0`, go to RESP.
    - Else if `tries == MAX_TRIES-1`: `rsp_data <= limit_q`, `rsp_timeout <= 1`, go to RESP.
    - Else `tries <= tries + 1`.
    - The state steps on every SEARCH cycle, accepting cycles included, so a value is never consumed twice.
  - RESP: `rsp_valid` = 1. `rsp_data` and `rsp_timeout` stay stable until `rsp_ready` = 1, then go to IDLE. `rsp_valid` must not drop without `rsp_ready`.
- `load` during SEARCH replaces the state. The next evaluation uses the loaded value; `tries` is not reset.
- If `limit_q` ≥ 2^OUT_W − 1, the first candidate is always accepted.
- `tries` width is clog2(MAX_TRIES+1).
- **Reset values:**
  - state = SEED (or 1), so `num` = SEED.
  - FSM = IDLE.
  - `req_ready` = 1.
  - `rsp_valid`, `rsp_timeout`, `lockup_o` = 0.
  - `rsp_data` = 0.
- Reset mid-SEARCH or mid-RESP aborts the request: no response is issued, and the block returns to reset values.

## Timing
- `num` updates on the cycle after a step, load or recovery.
- Request latency: handshake in cycle 0, first evaluation in cycle 1, `rsp_valid` rises in cycle 2 + R, where R is the number of rejections.
- Worst case: `rsp_valid` in cycle 1 + MAX_TRIES.
- `req_ready` is low from the cycle after the handshake until the cycle after `rsp_valid && rsp_ready`. The minimum request-to-request spacing is therefore 3 cycles.
- `lockup_o` is registered: high for exactly one cycle, the cycle in which `num` first shows 1 after recovery.

## Test plan
- **Reset sequence (default parameters):** release `rst`, hold `en` = 1 → `num` = 1, 2, 4, 8, 16, 32, 64, 129, 258, 516, 9 on consecutive cycles. The state returns to 1 after exactly 1023 steps and is never 0.
- **Immediate accept:** `en` = 0, state = 1, request with `limit_i` = 200 → handshake in cycle 0; `rsp_valid` = 1, `rsp_data` = 1, `rsp_timeout` = 0 in cycle 2. Hold `rsp_ready` = 0 for 3 cycles → outputs stable.
- **Rejection:** load `seed_i` = 16, then request with `limit_i` = 3 → candidates 16, 32, 64, 129 are rejected. `rsp_data` = 2 (from 258) with `rsp_valid` in cycle 6.
- **Timeout:** instance with `MAX_TRIES` = 2, load 16, request with `limit_i` = 0 → `rsp_valid` in cycle 3, `rsp_data` = 0, `rsp_timeout` = 1.
- **Lock-up and zero seed:** instance with `TAPS` = 10'h004, load 10'h200 with `en` = 1 → `num` = 0, then 1 with a single-cycle `lockup_o` pulse. Separately, `load` with `seed_i` = 0 → `num` = 1.
- **Reset mid-search:** assert `rst` during SEARCH → `rsp_valid` = 0 immediately, `num` = SEED, `req_ready` = 1. After release, the next request completes normally.
